// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: LSB-first bits into WIDTH-bit words, one-entry valid/ready output buffer.
// Define SHIFT_DESER_PARITY_EN to expect a trailing even-parity bit per word and flag errors on parity_err.
module shift_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ser_in,
    input  logic                           ser_valid,
    input  logic                           ser_sync,
    output logic [WIDTH-1:0]               data_out,
    output logic                           data_valid,
    input  logic                           data_ready,
    output logic                           overrun,
    input  logic                           overrun_clr,
    output logic                           parity_err,
    output logic [$clog2(WIDTH+1)-1:0]     bit_cnt
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

    buf_state_e        state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              ovr_q, ovr_d;
    logic              complete_c;
    logic [WIDTH-1:0]  word_c;
`ifdef SHIFT_DESER_PARITY_EN
    logic              perr_q, perr_d;
    logic              perr_c;
`endif

    // Assembly: sync restarts the frame with the current bit as bit 0.
    always_comb begin
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        complete_c = 1'b0;
        word_c     = shreg_q;
`ifdef SHIFT_DESER_PARITY_EN
        perr_c     = 1'b0;
`endif
        if (ser_valid) begin
            if (ser_sync) begin
                shreg_d = {ser_in, {(WIDTH-1){1'b0}}};
                cnt_d   = CW'(1);
            end
`ifdef SHIFT_DESER_PARITY_EN
            else if (cnt_q == CW'(WIDTH)) begin
                // Parity slot: the data word is already complete in shreg_q.
                complete_c = 1'b1;
                word_c     = shreg_q;
                perr_c     = ^{shreg_q, ser_in};
                cnt_d      = '0;
            end
`endif
            else begin
                shreg_d = {ser_in, shreg_q[WIDTH-1:1]};
`ifdef SHIFT_DESER_PARITY_EN
                cnt_d   = cnt_q + CW'(1);
`else
                if (cnt_q == CW'(WIDTH - 1)) begin
                    complete_c = 1'b1;
                    word_c     = shreg_d;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovr_d   = overrun_clr ? 1'b0 : ovr_q;
        unique case (state_q)
            EMPTY: begin
                if (complete_c) begin
                    state_d = FULL;
                    data_d  = word_c;
                end
            end
            FULL: begin
                if (complete_c && data_ready) begin
                    data_d = word_c;
                end else if (complete_c) begin
                    ovr_d = 1'b1;
                end else if (data_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

`ifdef SHIFT_DESER_PARITY_EN
    always_comb begin
        perr_d = overrun_clr ? 1'b0 : perr_q;
        if (perr_c) perr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = (state_q == FULL);
    assign overrun    = ovr_q;
    assign bit_cnt    = cnt_q;
endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: directed scenarios plus random traffic against a queue-based frame model.
module tb_shift_deserializer;
  localparam int WIDTH = 8;
  localparam int CW = $clog2(WIDTH + 1);
`ifdef SHIFT_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FRAME = WIDTH;
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser_in = 1'b0, ser_valid = 1'b0, ser_sync = 1'b0;
  logic data_ready = 1'b0, overrun_clr = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic data_valid, overrun, parity_err;
  logic [CW-1:0] bit_cnt;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  bit mq[$];
  logic [WIDTH-1:0] exp_data = '0;
  logic [WIDTH-1:0] exp_q[$];
  logic exp_valid = 1'b0, exp_ovr = 1'b0, exp_perr = 1'b0;

  shift_deserializer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .ser_sync(ser_sync),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .parity_err(parity_err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    exp_data = '0;
    exp_valid = 1'b0;
    exp_ovr = 1'b0;
    exp_perr = 1'b0;
  endtask

  // One clock edge of the specified behaviour, applied to the inputs presented before it.
  task automatic model_edge(input bit v, input bit s, input bit b, input bit r, input bit c);
    bit done = 1'b0;
    bit perr = 1'b0;
    logic [WIDTH-1:0] w = '0;
    if (v) begin
      if (s) mq.delete();
      mq.push_back(b);
      if (mq.size() == FRAME) begin
        int ones = 0;
        for (int i = 0; i < FRAME; i++) ones += mq[i];
        for (int i = 0; i < WIDTH; i++) w = w + (WIDTH'(mq[i]) << i);
        perr = PAR && (ones % 2 == 1);
        done = 1'b1;
        mq.delete();
      end
    end
    if (c) begin
      exp_ovr = 1'b0;
      exp_perr = 1'b0;
    end
    if (perr) exp_perr = 1'b1;
    if (done) begin
      if (!exp_valid || r) begin
        exp_data = w;
        exp_valid = 1'b1;
        exp_q.push_back(w);
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (r) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic step(input bit v, input bit s, input bit b, input bit r, input bit c);
    ser_valid = v; ser_sync = s; ser_in = b; data_ready = r; overrun_clr = c;
    @(posedge clk);
    model_edge(v, s, b, r, c);
    #1;
    ser_valid = 1'b0; ser_sync = 1'b0; data_ready = 1'b0; overrun_clr = 1'b0;
  endtask

  // Sends a word (plus a correct parity bit when enabled); data_ready only on the final bit.
  task automatic send_word(input logic [WIDTH-1:0] w, input bit s, input bit gap, input bit ready_last);
    for (int i = 0; i < FRAME; i++) begin
      bit b = (i < WIDTH) ? w[i] : ^w;
      if (gap) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      step(1'b1, s && (i == 0), b, (i == FRAME - 1) && ready_last, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #7;
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    n_checks++; if (bit_cnt !== '0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
    do_reset();
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] w = 8'hA5;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, i == 0, (i < WIDTH) ? w[i] : ^w, 1'b0, 1'b0);
      if (i == FRAME - 2) begin
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", data_valid); end
      end
    end
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", data_valid); end
    n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", data_out); end
    n_checks++; if (bit_cnt !== '0) begin n_fail++; $display("FAIL basic_cnt: got %0d want 0", bit_cnt); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consume: got %b want 0", data_valid); end
    n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL basic_hold: got %h want a5", data_out); end
  endtask

  task automatic test_gapped();
    logic [WIDTH-1:0] w = 8'hA5;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, i == 0, (i < WIDTH) ? w[i] : ^w, 1'b0, 1'b0);
      if (i < FRAME - 1) begin
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bit_cnt !== CW'(i + 1)) begin n_fail++; $display("FAIL gapped_stall_cnt: got %0d want %0d", bit_cnt, i + 1); end
      end
    end
    n_checks++; if (data_valid !== 1'b1 || data_out !== 8'hA5) begin n_fail++; $display("FAIL gapped_data: got %b/%h want 1/a5", data_valid, data_out); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_resync();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bit_cnt !== CW'(3)) begin n_fail++; $display("FAIL resync_partial_cnt: got %0d want 3", bit_cnt); end
    send_word(8'h3C, 1'b1, 1'b0, 1'b0);
    n_checks++; if (data_valid !== 1'b1 || data_out !== 8'h3C) begin n_fail++; $display("FAIL resync_data: got %b/%h want 1/3c", data_valid, data_out); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    send_word(8'h11, 1'b1, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0);
    n_checks++; if (data_out !== 8'h11) begin n_fail++; $display("FAIL overrun_data: got %h want 11", data_out); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b want 1", data_valid); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clr: got %b want 0", overrun); end
  endtask

  task automatic test_back_to_back();
    send_word(8'h77, 1'b0, 1'b0, 1'b1);
    n_checks++; if (data_out !== 8'h77) begin n_fail++; $display("FAIL simul_data: got %h want 77", data_out); end
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL simul_valid: got %b want 1", data_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL simul_overrun: got %b want 0", overrun); end
  endtask

`ifdef SHIFT_DESER_PARITY_EN
  task automatic test_parity();
    do_reset();
    for (int i = 0; i < WIDTH; i++) step(1'b1, i == 0, i < 2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (data_out !== 8'h03 || data_valid !== 1'b1) begin n_fail++; $display("FAIL parity_bad_data: got %b/%h want 1/03", data_valid, data_out); end
    n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_bad_flag: got %b want 1", parity_err); end
    do_reset();
    for (int i = 0; i < WIDTH; i++) step(1'b1, i == 0, i < 2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (data_out !== 8'h03 || data_valid !== 1'b1) begin n_fail++; $display("FAIL parity_good_data: got %b/%h want 1/03", data_valid, data_out); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_good_flag: got %b want 0", parity_err); end
  endtask
`endif

  task automatic test_reset_midframe();
    send_word(8'h5A, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (data_out !== '0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_buffer: got %b/%h want 0/00", data_valid, data_out); end
    n_checks++; if (bit_cnt !== '0) begin n_fail++; $display("FAIL midrst_cnt: got %0d want 0", bit_cnt); end
    n_checks++; if (overrun !== 1'b0 || parity_err !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got %b%b want 00", overrun, parity_err); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      bit v = ($urandom_range(0, 3) != 0);
      bit s = ($urandom_range(0, 15) == 0);
      bit b = 1'($urandom_range(0, 1));
      bit r = ($urandom_range(0, 2) == 0);
      bit c = ($urandom_range(0, 15) == 0);
      step(v, s, b, r, c);
      n_checks++;
      if (data_valid !== exp_valid || data_out !== exp_data || overrun !== exp_ovr ||
          parity_err !== exp_perr || bit_cnt !== CW'(mq.size())) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got v=%b d=%h o=%b p=%b c=%0d want v=%b d=%h o=%b p=%b c=%0d",
                 n, data_valid, data_out, overrun, parity_err, bit_cnt,
                 exp_valid, exp_data, exp_ovr, exp_perr, mq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_resync();
    test_overrun();
    test_back_to_back();
`ifdef SHIFT_DESER_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
